rom: RTL and testbench

ROM -- requirements
Module: rom

---
 rtl/rom.sv | 62 ++++++
 tb/tb_rom.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom.sv
// Fixed-content ROM: word[i] = (17*i + 3) mod 2^WIDTH; out-of-range addresses read as zero.
// Define ROM_OUT_REG_EN to add a second output register stage (latency 2 instead of 1).
module rom #(
   parameter  int WIDTH     = 8,
   parameter  int DEPTH     = 16,
   localparam int DEPTH_LOG = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DEPTH_LOG-1:0] addr_rd,
   output logic [WIDTH-1:0]     data_out
);

   // The table spans the full address space, so addresses at or above DEPTH
   // hit zero entries and need no separate range check.
   localparam int ROM_SIZE = 1 << DEPTH_LOG;

   logic [WIDTH-1:0] rom_mem [ROM_SIZE];
   logic [WIDTH-1:0] rd_next;
   logic [WIDTH-1:0] rd_reg;

   genvar gi;
   generate
      for (gi = 0; gi < ROM_SIZE; gi++) begin : g_word
         if (gi < DEPTH) begin : g_valid
            localparam logic [63:0] WORD_VAL = 64'(17 * gi + 3);
            assign rom_mem[gi] = WORD_VAL[WIDTH-1:0];
         end else begin : g_pad
            assign rom_mem[gi] = '0;
         end
      end
   endgenerate

   always_comb begin
      rd_next = rom_mem[addr_rd];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_reg <= '0;
      end else begin
         rd_reg <= rd_next;
      end
   end

`ifdef ROM_OUT_REG_EN
   logic [WIDTH-1:0] out_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg <= '0;
      end else begin
         out_reg <= rd_reg;
      end
   end

   assign data_out = out_reg;
`else
   assign data_out = rd_reg;
`endif

endmodule

// File: tb/tb_rom.sv
// Bench for rom: default 16x8 instance plus a 10-deep instance for out-of-range reads.
// Expected words come from a reference formula and flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_rom;

`ifdef ROM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] addr_rd;
   logic [7:0] data_out;
   logic [3:0] addr10;
   logic [7:0] data10;

   int checks;
   int errors;
   logic [7:0] exp_q [$];
   logic [7:0] exp10_q [$];

   rom #(.WIDTH(8), .DEPTH(16)) u_rom (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr_rd  (addr_rd),
      .data_out (data_out)
   );

   rom #(.WIDTH(8), .DEPTH(10)) u_rom10 (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr_rd  (addr10),
      .data_out (data10)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [7:0] model(input int a, input int depth);
      int v;
      if (a >= depth) return 8'h00;
      v = (17 * a + 3) % 256;
      return v[7:0];
   endfunction

   task automatic test_reset();
      rst_n   = 1'b0;
      addr_rd = 4'd3;
      addr10  = 4'd3;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (data_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_state data_out=%h expected=%h", data_out, 8'h00);
      end
      checks++;
      if (data10 !== 8'h00) begin
         errors++;
         $display("FAIL reset_state10 data_out=%h expected=%h", data10, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset: data_out=%h data10=%h", data_out, data10);
   endtask

   task automatic test_sweep();
      logic [7:0] e;
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         addr_rd = 4'(a);
         exp_q.push_back(model(a, 16));
         repeat (LAT) @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (data_out !== e) begin
            errors++;
            $display("FAIL sweep addr=%0d data_out=%h expected=%h", a, data_out, e);
         end else begin
            $display("sweep addr=%0d data_out=%h", a, data_out);
         end
         if (LAT < 2) @(posedge clk);
      end
   endtask

   task automatic test_latency();
      logic [7:0] e;
      @(negedge clk);
      addr_rd = 4'd0;
      repeat (LAT + 1) @(posedge clk);
      #1;
      addr_rd = 4'd5;
      #2;
      checks++;
      if (data_out !== 8'h03) begin
         errors++;
         $display("FAIL latency_hold data_out=%h expected=%h", data_out, 8'h03);
      end
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk);
         #1;
         e = (k >= LAT) ? 8'h58 : 8'h03;
         checks++;
         if (data_out !== e) begin
            errors++;
            $display("FAIL latency_edge%0d data_out=%h expected=%h", k, data_out, e);
         end else begin
            $display("latency edge%0d data_out=%h", k, data_out);
         end
      end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      addr_rd = 4'd7;
      addr10  = 4'd7;
      repeat (LAT + 1) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (data_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_async data_out=%h expected=%h", data_out, 8'h00);
      end
      checks++;
      if (data10 !== 8'h00) begin
         errors++;
         $display("FAIL reset_async10 data_out=%h expected=%h", data10, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if (data_out !== 8'h7a) begin
         errors++;
         $display("FAIL reset_release data_out=%h expected=%h", data_out, 8'h7a);
      end
      checks++;
      if (data10 !== 8'h7a) begin
         errors++;
         $display("FAIL reset_release10 data_out=%h expected=%h", data10, 8'h7a);
      end
      $display("reset mid-op: release data_out=%h data10=%h", data_out, data10);
   endtask

   task automatic test_depth10();
      int addrs [6] = '{9, 12, 10, 15, 0, 4};
      logic [7:0] e;
      foreach (addrs[i]) begin
         @(negedge clk);
         addr10 = 4'(addrs[i]);
         exp10_q.push_back(model(addrs[i], 10));
         repeat (LAT) @(posedge clk);
         #1;
         e = exp10_q.pop_front();
         checks++;
         if (data10 !== e) begin
            errors++;
            $display("FAIL depth10 addr=%0d data_out=%h expected=%h", addrs[i], data10, e);
         end else begin
            $display("depth10 addr=%0d data_out=%h", addrs[i], data10);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n = 40;
      int a;
      int b;
      logic [7:0] e;
      logic [7:0] e10;
      exp_q.delete();
      exp10_q.delete();
      for (int i = 0; i < n + LAT - 1; i++) begin
         @(negedge clk);
         if (i < n) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            addr_rd = 4'(a);
            addr10  = 4'(b);
            exp_q.push_back(model(a, 16));
            exp10_q.push_back(model(b, 10));
         end
         @(posedge clk);
         #1;
         if (i >= LAT - 1) begin
            e   = exp_q.pop_front();
            e10 = exp10_q.pop_front();
            checks++;
            if (data_out !== e) begin
               errors++;
               $display("FAIL b2b cycle=%0d data_out=%h expected=%h", i, data_out, e);
            end
            checks++;
            if (data10 !== e10) begin
               errors++;
               $display("FAIL b2b10 cycle=%0d data_out=%h expected=%h", i, data10, e10);
            end
            $display("b2b cycle=%0d data_out=%h data10=%h", i, data_out, data10);
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      addr_rd = '0;
      addr10  = '0;
      test_reset();
      test_sweep();
      test_latency();
      test_reset_midop();
      test_depth10();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
